// File: rtl/bram_stream_drain.sv
// rtl/bram_stream_drain.sv - drains a contiguous run of buffer words onto a valid/ready stream
// Reads are paced so that FIFO words plus the in-flight read never exceed the 2-entry FIFO.
module bram_stream_drain #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [ADDR_W-1:0] word_count_in,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic              rd_enable_out,
    input  logic [DATA_W-1:0] rd_data_in,
    input  logic              rd_valid_in,
    output logic [DATA_W-1:0] m_data_out,
    output logic              m_valid_out,
    output logic              m_last_out,
    input  logic              m_ready_in,
    output logic              busy_out,
    output logic              done_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] emitted_q, emitted_d;
    logic              inflight_q;

    logic [DATA_W-1:0] fifo_q [2];
    logic              head_q, tail_q;
    logic [1:0]        occ_q;

    logic       pop, push, issue;
    logic [2:0] pending;

    always_comb begin
        pop     = (occ_q != 2'd0) && m_ready_in;
        // Returns are only trusted when we issued a read last cycle; this drops stale data after reset.
        push    = rd_valid_in && inflight_q && ((occ_q != 2'd2) || pop);
        pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue   = (state_q == S_READ) && (remaining_q != '0) && (pending < 3'd2);
    end

    assign rd_enable_out = issue;
    assign rd_addr_out   = issue ? addr_q : last_addr_q;
    assign m_valid_out   = (occ_q != 2'd0);
    assign m_data_out    = m_valid_out ? fifo_q[head_q] : '0;
    assign m_last_out    = m_valid_out && (emitted_q == (count_q - ONE));
    assign busy_out      = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done_out      = (state_q == S_DONE);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        emitted_d   = pop ? (emitted_q + ONE) : emitted_q;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    if (word_count_in != '0) begin
                        state_d     = S_READ;
                        addr_d      = base_addr_in;
                        remaining_d = word_count_in;
                        count_d     = word_count_in;
                        emitted_d   = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                if (issue) begin
                    addr_d      = addr_q + ONE;
                    remaining_d = remaining_q - ONE;
                    if (remaining_q == ONE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && m_last_out) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            emitted_q   <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= rd_addr_out;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            emitted_q   <= emitted_d;
            inflight_q  <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[tail_q] <= rd_data_in;
                tail_q         <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_bram_stream_drain.sv
// tb/tb_bram_stream_drain.sv - self-checking bench for bram_stream_drain
// A behavioural buffer returns a hashed word per address one cycle after each read strobe.
module tb_bram_stream_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_in = 1'b0;
    logic [15:0] base_addr_in = '0;
    logic [15:0] word_count_in = '0;
    logic [15:0] rd_addr_out;
    logic        rd_enable_out;
    logic [15:0] rd_data_in = '0;
    logic        rd_valid_in = 1'b0;
    logic [15:0] m_data_out;
    logic        m_valid_out;
    logic        m_last_out;
    logic        m_ready_in = 1'b0;
    logic        busy_out;
    logic        done_out;

    always #5 clk = ~clk;

    bram_stream_drain #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start_in(start_in),
        .base_addr_in(base_addr_in), .word_count_in(word_count_in),
        .rd_addr_out(rd_addr_out), .rd_enable_out(rd_enable_out),
        .rd_data_in(rd_data_in), .rd_valid_in(rd_valid_in),
        .m_data_out(m_data_out), .m_valid_out(m_valid_out), .m_last_out(m_last_out),
        .m_ready_in(m_ready_in), .busy_out(busy_out), .done_out(done_out)
    );

    logic [15:0] salt;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ {a[7:0], a[15:8]} ^ salt;
    endfunction

    // Buffer model is deliberately not reset so stale returns after a reset reach the DUT.
    always @(posedge clk) begin
        rd_valid_in <= rd_enable_out;
        rd_data_in  <= mem_word(rd_addr_out);
    end

    int errors = 0;
    int checks = 0;

    logic [15:0] q_addr[$];
    logic [15:0] q_word[$];
    logic        q_last[$];
    int first_read, first_valid, last_hs, done_cyc, busy_cnt, stall_err, max_out, timed_out, busy_at_done;

    task automatic do_run(input logic [15:0] base, input logic [15:0] cnt, input int pct, input bit inject);
        int issued = 0;
        int popped = 0;
        bit pv = 0, pr = 0, seen_done = 0;
        logic [15:0] pd = '0;
        logic pl = 1'b0;
        q_addr.delete(); q_word.delete(); q_last.delete();
        first_read = -1; first_valid = -1; last_hs = -1; done_cyc = -1;
        busy_cnt = 0; stall_err = 0; max_out = 0; timed_out = 1; busy_at_done = 0;
        start_in = 1'b1; base_addr_in = base; word_count_in = cnt;
        m_ready_in = ($urandom_range(0, 99) < pct);
        for (int c = 0; c < 400; c++) begin
            #4;
            if (rd_enable_out) begin
                q_addr.push_back(rd_addr_out);
                issued++;
                if (first_read < 0) first_read = c;
            end
            if (pv && !pr && (!m_valid_out || m_data_out !== pd || m_last_out !== pl)) stall_err++;
            if (m_valid_out) begin
                if (first_valid < 0) first_valid = c;
                if (m_ready_in) begin
                    q_word.push_back(m_data_out);
                    q_last.push_back(m_last_out);
                    popped++;
                    last_hs = c;
                end
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (busy_out) busy_cnt++;
            if (done_out) begin
                done_cyc = c;
                seen_done = 1;
                if (busy_out) busy_at_done++;
            end
            pv = m_valid_out; pr = m_ready_in; pd = m_data_out; pl = m_last_out;
            @(posedge clk); #1;
            start_in = inject && (c == 2);
            if (inject && c == 2) begin
                base_addr_in = 16'h0200;
                word_count_in = 16'd5;
            end
            m_ready_in = ($urandom_range(0, 99) < pct);
            if (seen_done) begin
                timed_out = 0;
                break;
            end
        end
        start_in = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        checks++;
        if ({rd_enable_out, rd_addr_out, m_valid_out, m_last_out} !== 19'd0) begin
            errors++;
            $display("FAIL reset_rd_stream: got en=%b addr=%h valid=%b last=%b expected all 0", rd_enable_out, rd_addr_out, m_valid_out, m_last_out);
        end
        checks++;
        if ({m_data_out, busy_out, done_out} !== 18'd0) begin
            errors++;
            $display("FAIL reset_data_status: got data=%h busy=%b done=%b expected all 0", m_data_out, busy_out, done_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        do_run(16'h0010, 16'd4, 100, 0);
        checks++;
        if (timed_out !== 0) begin errors++; $display("FAIL basic_timeout: got %0d expected 0", timed_out); end
        checks++;
        if (q_addr.size() !== 4 || q_word.size() !== 4) begin
            errors++; $display("FAIL basic_counts: got addrs=%0d words=%0d expected 4", q_addr.size(), q_word.size());
        end
        for (int i = 0; i < 4 && i < q_word.size() && i < q_addr.size(); i++) begin
            logic [15:0] ea;
            ea = 16'h0010 + 16'(i);
            checks++;
            if (q_addr[i] !== ea || q_word[i] !== mem_word(ea) || q_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL basic_word%0d: got addr=%h data=%h last=%b expected addr=%h data=%h last=%b", i, q_addr[i], q_word[i], q_last[i], ea, mem_word(ea), (i == 3));
            end
        end
        checks++;
        if (first_read !== 1 || first_valid !== 3) begin
            errors++; $display("FAIL basic_latency: got read@%0d valid@%0d expected read@1 valid@3", first_read, first_valid);
        end
        checks++;
        if (last_hs !== 6 || done_cyc !== 7) begin
            errors++; $display("FAIL basic_done_timing: got last_hs@%0d done@%0d expected 6 and 7", last_hs, done_cyc);
        end
        checks++;
        if (busy_at_done !== 0) begin errors++; $display("FAIL basic_busy_at_done: got %0d expected 0", busy_at_done); end
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++;
            if (done_out !== 1'b0 || m_valid_out !== 1'b0 || busy_out !== 1'b0) begin
                errors++; $display("FAIL basic_idle_after: got done=%b valid=%b busy=%b expected 0", done_out, m_valid_out, busy_out);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] base;
        base = 16'($urandom_range(0, 16'hFF00));
        do_run(base, 16'd16, 50, 0);
        checks++;
        if (timed_out !== 0 || q_word.size() !== 16 || q_addr.size() !== 16) begin
            errors++; $display("FAIL bp_counts: got timeout=%0d words=%0d addrs=%0d expected 0/16/16", timed_out, q_word.size(), q_addr.size());
        end
        for (int i = 0; i < 16 && i < q_word.size() && i < q_addr.size(); i++) begin
            logic [15:0] ea;
            ea = base + 16'(i);
            checks++;
            if (q_addr[i] !== ea || q_word[i] !== mem_word(ea) || q_last[i] !== (i == 15)) begin
                errors++;
                $display("FAIL bp_word%0d: got addr=%h data=%h last=%b expected addr=%h data=%h last=%b", i, q_addr[i], q_word[i], q_last[i], ea, mem_word(ea), (i == 15));
            end
        end
        checks++;
        if (stall_err !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_err); end
        checks++;
        if (max_out > 2) begin errors++; $display("FAIL bp_occupancy: got max outstanding %0d expected <= 2", max_out); end
    endtask

    task automatic test_zero_count;
        do_run(16'($urandom), 16'd0, 100, 0);
        checks++;
        if (q_addr.size() !== 0 || first_valid !== -1) begin
            errors++; $display("FAIL zero_activity: got reads=%0d first_valid=%0d expected 0 and -1", q_addr.size(), first_valid);
        end
        checks++;
        if (done_cyc !== 1 || busy_cnt !== 0) begin
            errors++; $display("FAIL zero_done: got done@%0d busy_cycles=%0d expected done@1 busy 0", done_cyc, busy_cnt);
        end
    endtask

    task automatic test_wrap;
        do_run(16'hFFFE, 16'd4, 70, 0);
        checks++;
        if (timed_out !== 0 || q_word.size() !== 4 || q_addr.size() !== 4) begin
            errors++; $display("FAIL wrap_counts: got timeout=%0d words=%0d addrs=%0d expected 0/4/4", timed_out, q_word.size(), q_addr.size());
        end
        for (int i = 0; i < 4 && i < q_word.size() && i < q_addr.size(); i++) begin
            logic [15:0] ea;
            ea = 16'hFFFE + 16'(i);
            checks++;
            if (q_addr[i] !== ea || q_word[i] !== mem_word(ea)) begin
                errors++; $display("FAIL wrap_word%0d: got addr=%h data=%h expected addr=%h data=%h", i, q_addr[i], q_word[i], ea, mem_word(ea));
            end
        end
    endtask

    task automatic test_ignored_start;
        do_run(16'h0300, 16'd6, 100, 1);
        checks++;
        if (timed_out !== 0 || q_word.size() !== 6 || q_addr.size() !== 6) begin
            errors++; $display("FAIL ign_counts: got timeout=%0d words=%0d addrs=%0d expected 0/6/6", timed_out, q_word.size(), q_addr.size());
        end
        for (int i = 0; i < 6 && i < q_word.size() && i < q_addr.size(); i++) begin
            logic [15:0] ea;
            ea = 16'h0300 + 16'(i);
            checks++;
            if (q_addr[i] !== ea || q_word[i] !== mem_word(ea) || q_last[i] !== (i == 5)) begin
                errors++; $display("FAIL ign_word%0d: got addr=%h data=%h last=%b expected addr=%h data=%h", i, q_addr[i], q_word[i], q_last[i], ea, mem_word(ea));
            end
        end
        for (int i = 0; i < 5; i++) begin
            #4;
            checks++;
            if (rd_enable_out !== 1'b0 || busy_out !== 1'b0) begin
                errors++; $display("FAIL ign_idle: got en=%b addr=%h busy=%b expected idle", rd_enable_out, rd_addr_out, busy_out);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] base;
        do_run(16'h1234, 16'd3, 100, 0);
        checks++;
        if (timed_out !== 0 || q_word.size() !== 3) begin
            errors++; $display("FAIL b2b_first: got timeout=%0d words=%0d expected 0/3", timed_out, q_word.size());
        end
        base = 16'($urandom);
        do_run(base, 16'd5, 100, 0);
        checks++;
        if (first_read !== 1 || timed_out !== 0 || q_word.size() !== 5) begin
            errors++; $display("FAIL b2b_second: got read@%0d timeout=%0d words=%0d expected read@1 0 5", first_read, timed_out, q_word.size());
        end
        for (int i = 0; i < 5 && i < q_word.size(); i++) begin
            logic [15:0] ea;
            ea = base + 16'(i);
            checks++;
            if (q_word[i] !== mem_word(ea)) begin
                errors++; $display("FAIL b2b_word%0d: got %h expected %h", i, q_word[i], mem_word(ea));
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int reads = 0;
        bit hit = 0;
        start_in = 1'b1; base_addr_in = 16'h4000; word_count_in = 16'd8; m_ready_in = 1'b1;
        for (int c = 0; c < 50 && !hit; c++) begin
            #4;
            if (rd_enable_out) reads++;
            @(posedge clk); #1;
            start_in = 1'b0;
            if (reads == 3) hit = 1;
        end
        checks++;
        if (hit !== 1) begin errors++; $display("FAIL rst_mid_reads: got %0d reads expected 3", reads); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #4;
        checks++;
        if ({rd_enable_out, rd_addr_out, m_valid_out, m_last_out, m_data_out, busy_out, done_out} !== 37'd0) begin
            errors++; $display("FAIL rst_mid_outputs: got en=%b addr=%h valid=%b last=%b data=%h busy=%b done=%b expected all 0",
                rd_enable_out, rd_addr_out, m_valid_out, m_last_out, m_data_out, busy_out, done_out);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #5;
            checks++;
            if (m_valid_out !== 1'b0 || rd_enable_out !== 1'b0) begin
                errors++; $display("FAIL rst_mid_stale: got valid=%b en=%b expected 0", m_valid_out, rd_enable_out);
            end
        end
        @(posedge clk); #1;
        do_run(16'h0100, 16'd2, 100, 0);
        checks++;
        if (timed_out !== 0 || q_word.size() !== 2) begin
            errors++; $display("FAIL rst_new_count: got timeout=%0d words=%0d expected 0/2", timed_out, q_word.size());
        end
        for (int i = 0; i < 2 && i < q_word.size(); i++) begin
            logic [15:0] ea;
            ea = 16'h0100 + 16'(i);
            checks++;
            if (q_word[i] !== mem_word(ea) || q_last[i] !== (i == 1)) begin
                errors++; $display("FAIL rst_new_word%0d: got data=%h last=%b expected data=%h last=%b", i, q_word[i], q_last[i], mem_word(ea), (i == 1));
            end
        end
    endtask

    initial begin
        salt = 16'($urandom);
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_wrap();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bram_stream_drain.md
Name: bram_stream_drain

Overview:
- Downstream reader for the arithmetic-encoder BRAM stream buffer wrapper.
- On a start command, reads a contiguous run of 16-bit words from the buffer's read port and presents them in order on a valid/ready output stream, with a last flag on the final word.
- Absorbs the buffer's fixed 1-cycle read latency with a 2-entry output FIFO, so it sustains 1 word/cycle while the sink stays ready and never drops or duplicates a word under backpressure.

Parameters:
- ADDR_W, 16, width of buffer read address and word count
- DATA_W, 16, width of buffer data words and of the output stream

Ports:
- clk  input  1  single clock for all logic
- rst  input  1  reset, synchronous, active-high
- start_in  input  1  one-cycle command pulse; sampled only in IDLE
- base_addr_in  input  ADDR_W  first buffer address to read; sampled with start_in
- word_count_in  input  ADDR_W  number of words to read; sampled with start_in; 0 is legal
- rd_addr_out  output  ADDR_W  buffer read address
- rd_enable_out  output  1  buffer read strobe
- rd_data_in  input  DATA_W  buffer read data
- rd_valid_in  input  1  buffer read-data valid, asserted 1 cycle after rd_enable_out
- m_data_out  output  DATA_W  output stream data
- m_valid_out  output  1  output stream valid
- m_last_out  output  1  high with the final word of a run
- m_ready_in  input  1  output stream ready from the sink
- busy_out  output  1  high from the cycle after an accepted start until done
- done_out  output  1  one-cycle pulse when a run completes

Behaviour:
- Reset values: rd_enable_out=0, rd_addr_out=0, m_valid_out=0, m_last_out=0, m_data_out=0, busy_out=0, done_out=0. Reset also clears the FIFO, all counters and the in-flight flag.
- States: IDLE, READ, DRAIN, DONE.
- IDLE -> READ: start_in=1 and word_count_in!=0. Latch the base address and count; remaining := count; emitted := 0.
- IDLE -> DONE: start_in=1 and word_count_in=0. No reads are issued and no words are output.
- start_in in any state other than IDLE is ignored.
- Read issue rule (READ state only): assert rd_enable_out when remaining!=0 and (fifo_occupancy + inflight - pop) < 2.
  - pop = m_valid_out & m_ready_in in the same cycle.
  - inflight = rd_enable_out was asserted in the previous cycle.
  - This rule gives full throughput with no FIFO overflow.
- Each issued read: rd_addr_out = current address; then address := address+1, modulo 2^ADDR_W (wraps FFFF -> 0000); remaining := remaining-1.
- rd_addr_out holds its last value when rd_enable_out=0.
- rd_valid_in pushes rd_data_in into the FIFO tail.
  - It is honoured only when inflight=1; otherwise it is ignored (this covers stale returns after reset).
  - Push and pop in the same cycle are legal, and occupancy is unchanged.
- Output stream: m_valid_out=1 whenever the FIFO is non-empty, and m_data_out is the FIFO head.
  - While m_valid_out=1 and m_ready_in=0, data and last stay stable.
  - m_valid_out is never withdrawn without a handshake.
- m_last_out=1 exactly when the head word is word index count-1 (tracked by the emitted counter).
- READ -> DRAIN: the cycle after the final read issues (remaining becomes 0).
- DRAIN -> DONE: on the handshake of the last word.
- DONE: done_out=1 for exactly one cycle, busy_out=0 in that cycle, then -> IDLE.
- busy_out=1 in READ and DRAIN.
- A start_in accepted on the cycle DONE returns to IDLE is legal; the back-to-back gap is 1 cycle.
- Latency: start accepted at cycle t gives the first read at t+1 and the first m_valid_out at t+3.
- Sustained rate: 1 word/cycle while m_ready_in=1.
- Reset asserted mid-run: all outputs return to their reset values on the next edge. Any read return arriving afterwards is discarded. The next start_in begins a fresh run.

Test Plan:
- Basic run: base=0x0010, count=4, m_ready_in=1 throughout.
  - rd_addr_out = 0x0010..0x0013 on 4 consecutive cycles.
  - 4 words out in order on consecutive cycles; m_last_out only on the 4th.
  - done_out pulses once, 1 cycle after the last handshake.
- Backpressure: count=16, m_ready_in driven by pseudo-random toggling (~50%).
  - All 16 words are delivered exactly once and in order.
  - Data stays stable while stalled.
  - FIFO occupancy never exceeds 2; rd_enable_out is never high with a full FIFO, an in-flight read and no pop.
- Zero count: start with count=0.
  - No rd_enable_out and no m_valid_out.
  - done_out pulses on the cycle after start; busy_out stays 0.
- Address wrap: base=0xFFFE, count=4.
  - rd_addr_out sequence is 0xFFFE, 0xFFFF, 0x0000, 0x0001; data is returned in that order.
- Reset mid-run: count=8, assert rst after the 3rd read is issued, while the 3rd word's return is in flight.
  - All outputs are at reset values on the next cycle; the in-flight return is ignored.
  - A new run with base=0x0100, count=2 then delivers exactly 2 correct words.
- Ignored start: pulse start_in with base=0x0200, count=5 while busy with a count=6 run.
  - The original run completes with 6 words.
  - No reads are issued to 0x0200 until a new start is given in IDLE.
